fpu_unit_arbiter: RTL and testbench

//  Shares one set of multi-cycle FPU FSM units (add/sub, mul, div) between two requesters.

---
 rtl/fpu_unit_arbiter_pkg.sv | 39 +++
 rtl/fpu_unit_arbiter_rr_arb2.sv | 32 +++
 rtl/fpu_unit_arbiter.sv | 156 +++++++++++++++
 tb/tb_fpu_unit_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_unit_arbiter_pkg.sv
// Shared definitions for the FPU unit arbiter: op codes, FSM states,
// unit indices and the default error result.
package fpu_unit_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fpu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } arb_state_t;

    localparam int N_UNITS     = 3;
    localparam int UNIT_ADDSUB = 0;
    localparam int UNIT_MUL    = 1;
    localparam int UNIT_DIV    = 2;

    localparam logic [31:0] ERR_RESULT_DEF = 32'h7FC00000;

    // ADD and SUB share the add/sub unit; fpu_sub selects the mode.
    function automatic logic [N_UNITS-1:0] unit_onehot(input fpu_op_t op);
        logic [N_UNITS-1:0] oh;
        oh = '0;
        case (op)
            OP_ADD, OP_SUB: oh[UNIT_ADDSUB] = 1'b1;
            OP_MUL:         oh[UNIT_MUL]    = 1'b1;
            default:        oh[UNIT_DIV]    = 1'b1;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/fpu_unit_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves past the
// requester shown on req when update is pulsed.
module fpu_unit_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // ptr_q = 1 means requester 1 has priority on a tie.
    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (update && (gnt != 2'b00)) begin
            ptr_q <= gnt[0];
        end
    end

endmodule

// File: rtl/fpu_unit_arbiter.sv
// Shares the add/sub, mul and div FPU units between two requesters:
// round-robin grant, one transaction in flight, watchdog-bounded wait.
module fpu_unit_arbiter
    import fpu_unit_arbiter_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RESULT     = ERR_RESULT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_sub,
    output logic [2:0]  unit_start,
    input  logic [2:0]  unit_done,
    input  logic [95:0] unit_result,
    output logic        busy
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t          state_q, state_d;
    logic                owner_q;
    logic [31:0]         a_q, b_q, res_q;
    logic                sub_q, err_q;
    logic [N_UNITS-1:0]  sel_oh_q;
    logic [WD_W-1:0]     wdog_q;

    logic [1:0]          arb_req, arb_gnt;
    logic                arb_upd;
    fpu_op_t             g_op;
    logic [31:0]         g_a, g_b, res_sel;
    logic                done_hit, wd_expired;

    fpu_unit_arbiter_rr_arb2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (arb_req),
        .update (arb_upd),
        .gnt    (arb_gnt)
    );

    // Owner lane selection and selected-unit result/done
    always_comb begin
        g_op    = owner_q ? fpu_op_t'(req_op[3:2]) : fpu_op_t'(req_op[1:0]);
        g_a     = owner_q ? req_a[63:32] : req_a[31:0];
        g_b     = owner_q ? req_b[63:32] : req_b[31:0];
        res_sel = unit_result[31:0];
        if (sel_oh_q[UNIT_MUL]) res_sel = unit_result[63:32];
        if (sel_oh_q[UNIT_DIV]) res_sel = unit_result[95:64];
        done_hit   = |(unit_done & sel_oh_q);
        wd_expired = (wdog_q == WD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 2'b00;
        unit_start = 3'b000;
        rsp_valid  = 2'b00;
        rsp_data   = 32'h0;
        rsp_err    = 1'b0;
        arb_req    = req_valid;
        arb_upd    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid != 2'b00) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                req_ready[owner_q] = 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                unit_start = sel_oh_q;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_hit || wd_expired) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                rsp_data = res_q;
                rsp_err  = err_q;
                // Present the owner to the arbiter so its pointer moves past it.
                arb_req  = owner_q ? 2'b10 : 2'b01;
                arb_upd  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= 1'b0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            sub_q    <= 1'b0;
            sel_oh_q <= '0;
            res_q    <= 32'h0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid != 2'b00) owner_q <= arb_gnt[1];
                end
                ST_GRANT: begin
                    a_q      <= g_a;
                    b_q      <= g_b;
                    sub_q    <= (g_op == OP_SUB);
                    sel_oh_q <= unit_onehot(g_op);
                    err_q    <= 1'b0;
                end
                ST_ISSUE: begin
                    wdog_q <= '0;
                end
                ST_WAIT: begin
                    // A done in the last watchdog cycle still wins over the timeout.
                    if (done_hit) begin
                        res_q <= res_sel;
                        err_q <= 1'b0;
                    end else if (wd_expired) begin
                        res_q <= ERR_RESULT;
                        err_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fpu_a   = a_q;
    assign fpu_b   = b_q;
    assign fpu_sub = sub_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_unit_arbiter.sv
// Directed bench for fpu_unit_arbiter with a latency-programmable unit model.
module tb_fpu_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_a, req_b;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_sub;
    logic [2:0]  unit_start, unit_done;
    logic [95:0] unit_result;
    logic        busy;

    always #5 clk = ~clk;

    fpu_unit_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sub(fpu_sub),
        .unit_start(unit_start), .unit_done(unit_done), .unit_result(unit_result),
        .busy(busy)
    );

    // Unit model: done for the started unit mdl_lat cycles after start is seen.
    logic [2:0]  mdl_done = 3'b000;
    logic [2:0]  stray_done;
    logic [2:0]  act = 3'b000;
    int          cnt = 0;
    int          mdl_lat;
    logic        mdl_hold;
    logic [31:0] mdl_res [3];

    always @(posedge clk) begin
        mdl_done <= 3'b000;
        if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1 && !mdl_hold) mdl_done <= act;
        end
        if (unit_start != 3'b000) begin
            act <= unit_start;
            cnt <= mdl_lat;
        end
    end

    assign unit_done   = mdl_done | stray_done;
    assign unit_result = {mdl_res[2], mdl_res[1], mdl_res[0]};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act_v, exp_v);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready == 2'b00) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: req_ready never asserted, got %b, expected nonzero", name, req_ready);
        end
    endtask

    task automatic wait_rsp(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == 2'b00 && n < 200);
        if (rsp_valid == 2'b00) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: rsp_valid never asserted, got %b, expected nonzero", name, rsp_valid);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_lane(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req_op = {op, 2'b10};
            req_a  = {a, 32'h12345678};
            req_b  = {b, 32'h9ABCDEF0};
        end else begin
            req_op = {2'b01, op};
            req_a  = {32'h12345678, a};
            req_b  = {32'h9ABCDEF0, b};
        end
    endtask

    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  start;
        logic        sub;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        logic [1:0] oh;
        oh = v.id ? 2'b10 : 2'b01;
        for (int u = 0; u < 3; u++) mdl_res[u] = 32'hDEAD0000 | u;
        for (int u = 0; u < 3; u++) if (v.start[u]) mdl_res[u] = v.res;
        set_lane(v.id, v.op, v.a, v.b);
        req_valid = oh;
        wait_ready($sformatf("v%0d_ready", idx));
        chk($sformatf("v%0d_ready", idx), req_ready, oh);
        req_valid = 2'b00;
        @(negedge clk);
        chk($sformatf("v%0d_start", idx), unit_start, v.start);
        chk($sformatf("v%0d_fpu_a", idx), fpu_a, v.a);
        chk($sformatf("v%0d_fpu_b", idx), fpu_b, v.b);
        chk($sformatf("v%0d_fpu_sub", idx), fpu_sub, v.sub);
        wait_rsp($sformatf("v%0d_rsp", idx), n);
        chk($sformatf("v%0d_rsp_valid", idx), rsp_valid, oh);
        chk($sformatf("v%0d_rsp_data", idx), rsp_data, v.res);
        chk($sformatf("v%0d_rsp_err", idx), rsp_err, 0);
        @(negedge clk);
        chk($sformatf("v%0d_idle", idx), busy, 0);
    endtask

    initial begin
        int n, pulses;
        vecs[0] = '{1'b0, 2'b11, 32'h40C00000, 32'h40000000, 32'h40400000, 3'b100, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 32'h41100000, 32'h40400000, 32'h40C00000, 3'b001, 1'b1};
        vecs[2] = '{1'b0, 2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b001, 1'b0};
        vecs[3] = '{1'b1, 2'b10, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b010, 1'b0};
        vecs[4] = '{1'b0, 2'b11, 32'h3F800000, 32'h00000000, 32'h7F800000, 3'b100, 1'b0};
        vecs[5] = '{1'b1, 2'b00, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b001, 1'b0};

        rst_n = 1'b0;
        req_valid = 2'b00; req_op = 4'h0; req_a = 64'h0; req_b = 64'h0;
        stray_done = 3'b000; mdl_lat = 3; mdl_hold = 1'b0;
        for (int u = 0; u < 3; u++) mdl_res[u] = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_unit_start", unit_start, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_fpu_b", fpu_b, 0);
        chk("rst_fpu_sub", fpu_sub, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Simultaneous requests after reset: req0 first, then req1.
        do_reset();
        mdl_res[0] = 32'h40000000; mdl_res[1] = 32'h40C00000; mdl_res[2] = 32'hDEAD0002;
        req_op = {2'b00, 2'b10};
        req_a  = {32'h3F800000, 32'h40000000};
        req_b  = {32'h3F800000, 32'h40400000};
        req_valid = 2'b11;
        wait_ready("dual_g0");
        chk("dual_g0", req_ready, 2'b01);
        req_valid = 2'b10;
        wait_rsp("dual_r0", n);
        chk("dual_r0_valid", rsp_valid, 2'b01);
        chk("dual_r0_data", rsp_data, 32'h40C00000);
        wait_ready("dual_g1");
        chk("dual_g1", req_ready, 2'b10);
        req_valid = 2'b00;
        wait_rsp("dual_r1", n);
        chk("dual_r1_valid", rsp_valid, 2'b10);
        chk("dual_r1_data", rsp_data, 32'h40000000);

        // Both held for four operations: grants alternate.
        @(negedge clk);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ready($sformatf("alt_g%0d", k));
            chk($sformatf("alt_g%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
            if (k == 3) req_valid = 2'b00;
            wait_rsp($sformatf("alt_r%0d", k), n);
            chk($sformatf("alt_r%0d_valid", k), rsp_valid, (k % 2) ? 2'b10 : 2'b01);
            chk($sformatf("alt_r%0d_data", k), rsp_data, (k % 2) ? 32'h40000000 : 32'h40C00000);
        end
        @(negedge clk);

        // Done arrives in the last watchdog cycle: done wins.
        mdl_lat = 63;
        set_lane(1'b0, 2'b10, 32'h40000000, 32'h40400000);
        req_valid = 2'b01;
        wait_ready("tie_ready");
        req_valid = 2'b00;
        @(negedge clk);
        wait_rsp("tie_rsp", n);
        chk("tie_latency", n, 65);
        chk("tie_err", rsp_err, 0);
        chk("tie_data", rsp_data, 32'h40C00000);
        @(negedge clk);
        mdl_lat = 3;

        // Watchdog expiry.
        mdl_hold = 1'b1;
        set_lane(1'b0, 2'b10, 32'h40000000, 32'h40400000);
        req_valid = 2'b01;
        wait_ready("to_ready");
        req_valid = 2'b00;
        @(negedge clk);
        chk("to_start", unit_start, 3'b010);
        wait_rsp("to_rsp", n);
        chk("to_latency", n, 65);
        chk("to_valid", rsp_valid, 2'b01);
        chk("to_err", rsp_err, 1);
        chk("to_data", rsp_data, 32'h7FC00000);
        @(negedge clk);
        chk("to_idle", busy, 0);
        mdl_hold = 1'b0;

        // Stray mul done during a DIV wait is ignored.
        mdl_lat = 10;
        mdl_res[1] = 32'hBAD0BAD0; mdl_res[2] = 32'h40400000;
        set_lane(1'b0, 2'b11, 32'h40C00000, 32'h40000000);
        req_valid = 2'b01;
        wait_ready("stray_ready");
        req_valid = 2'b00;
        @(negedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            stray_done = (n == 3) ? 3'b010 : 3'b000;
        end while (rsp_valid == 2'b00 && n < 100);
        stray_done = 3'b000;
        chk("stray_latency", n, 12);
        chk("stray_data", rsp_data, 32'h40400000);
        chk("stray_valid", rsp_valid, 2'b01);
        @(negedge clk);
        mdl_lat = 3;

        // Reset while waiting: outputs clear, no response afterwards.
        mdl_hold = 1'b1;
        set_lane(1'b1, 2'b00, 32'h3F800000, 32'h3F800000);
        req_valid = 2'b10;
        wait_ready("mrst_ready");
        req_valid = 2'b00;
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("mrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_fpu_a", fpu_a, 0);
        chk("mrst_unit_start", unit_start, 0);
        chk("mrst_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) pulses++;
        end
        chk("mrst_no_rsp", pulses, 0);
        chk("mrst_idle", busy, 0);
        mdl_hold = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
